cordic_rot_sequencer: RTL and testbench

Control FSM that shares one iterative CORDIC rotator among the four vertices (v1..v4) produced by the pre-rotation stage. It takes one job per primitive from pre-rotation, including the enable-CORDIC flag, the bubble flag and the residual angle z. For each vertex it loads the rotator, steps it through ITERS micro-rotations while tracking z and issuing the rotation direction, and then writes the result back. It stalls the upstream stage through a valid/ready handshake while busy.

---
 rtl/cordic_rot_sequencer.sv | 157 +++++++++++++++
 tb/tb_cordic_rot_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rot_sequencer.sv
// cordic_rot_sequencer
// Sequences one shared iterative CORDIC rotator across the four vertices
// (v1..v4) of a primitive. A job is taken from the pre-rotation stage over a
// valid/ready handshake. For each vertex the sequencer loads the rotator and
// steps it through ITERS micro-rotations while it tracks the residual angle z.
// It then writes the result back. Bubble jobs and jobs that do not need
// rotation skip straight to DONE.
//
// Ports:
//   clk, reset            pipeline clock, async active-high reset
//   in_valid/in_ready     upstream job handshake (ready only in IDLE)
//   in_bubble, in_enable_cordic, in_z   job flags and initial angle
//   atan_val              atan ROM value for iter_idx (unsigned magnitude)
//   load, step_en, dir, iter_idx, vtx_sel, wr_en   rotator control
//   z_cur                 current residual angle
//   out_valid/out_ready   downstream job handshake
//   out_bubble, out_bypass captured job flags, valid with out_valid
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a job; in_ready=1
// LOAD  | rotator loads vertex vtx_sel; z_cur reset to the job angle
// ITER  | one micro-rotation per cycle, iter_idx 0..ITERS-1
// WRITE | rotator result of vtx_sel is captured downstream
// DONE  | job complete; hold out_valid until out_ready

module cordic_rot_sequencer #(
    parameter int ITERS = 16,
    parameter int ZW    = 19,
    parameter int IW    = $clog2(ITERS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_bubble,
    input  logic          in_enable_cordic,
    input  logic [ZW-1:0] in_z,
    input  logic [ZW-1:0] atan_val,
    output logic          load,
    output logic          step_en,
    output logic          dir,
    output logic [IW-1:0] iter_idx,
    output logic [1:0]    vtx_sel,
    output logic          wr_en,
    output logic [ZW-1:0] z_cur,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_bubble,
    output logic          out_bypass
);

    typedef enum logic [2:0] {IDLE, LOAD, ITER, WRITE, DONE} state_t;

    state_t        state, state_nxt;
    logic [ZW-1:0] z0;
    logic          bub;
    logic          byp;
    logic          last_iter;
    logic          z_pos;

    assign last_iter = (iter_idx == IW'(ITERS - 1));
    // Zero residual counts as positive.
    assign z_pos     = ~z_cur[ZW-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        load       = 1'b0;
        step_en    = 1'b0;
        dir        = 1'b0;
        wr_en      = 1'b0;
        out_valid  = 1'b0;
        out_bubble = 1'b0;
        out_bypass = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = (in_bubble | ~in_enable_cordic) ? DONE : LOAD;
                end
            end
            LOAD: begin
                load      = 1'b1;
                state_nxt = ITER;
            end
            ITER: begin
                step_en = 1'b1;
                dir     = z_pos;
                if (last_iter) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                wr_en     = 1'b1;
                state_nxt = (vtx_sel == 2'd3) ? DONE : LOAD;
            end
            DONE: begin
                out_valid  = 1'b1;
                out_bubble = bub;
                out_bypass = byp;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z0       <= '0;
            bub      <= 1'b0;
            byp      <= 1'b0;
            vtx_sel  <= 2'd0;
            iter_idx <= '0;
            z_cur    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        z0      <= in_z;
                        bub     <= in_bubble;
                        byp     <= in_bubble | ~in_enable_cordic;
                        vtx_sel <= 2'd0;
                    end
                end
                LOAD: begin
                    z_cur    <= z0;
                    iter_idx <= '0;
                end
                ITER: begin
                    // Drive z toward zero; the arithmetic wraps modulo 2^ZW.
                    z_cur <= z_pos ? (z_cur - atan_val) : (z_cur + atan_val);
                    if (!last_iter) begin
                        iter_idx <= iter_idx + IW'(1);
                    end
                end
                WRITE: begin
                    if (vtx_sel != 2'd3) begin
                        vtx_sel <= vtx_sel + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rot_sequencer.sv
module tb_cordic_rot_sequencer;

    localparam int ITERS = 16;
    localparam int ZW    = 19;
    localparam int IW    = $clog2(ITERS);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_bubble;
    logic          in_enable_cordic;
    logic [ZW-1:0] in_z;
    logic [ZW-1:0] atan_val;
    logic          load;
    logic          step_en;
    logic          dir;
    logic [IW-1:0] iter_idx;
    logic [1:0]    vtx_sel;
    logic          wr_en;
    logic [ZW-1:0] z_cur;
    logic          out_valid;
    logic          out_ready;
    logic          out_bubble;
    logic          out_bypass;

    cordic_rot_sequencer #(.ITERS(ITERS), .ZW(ZW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_bubble(in_bubble), .in_enable_cordic(in_enable_cordic), .in_z(in_z),
        .atan_val(atan_val),
        .load(load), .step_en(step_en), .dir(dir), .iter_idx(iter_idx),
        .vtx_sel(vtx_sel), .wr_en(wr_en), .z_cur(z_cur),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bubble(out_bubble), .out_bypass(out_bypass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench atan ROM: mode 0 gives 2^(15-i), mode 1 gives constant 1.
    logic rom_mode;
    always_comb begin
        atan_val = ZW'(1);
        if (!rom_mode) atan_val = ZW'(32'd1 << (15 - int'(iter_idx)));
    end

    typedef struct {
        logic bub;
        logic byp;
        int   lat;
        int   nload;
        int   nstep;
        int   nwr;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: tracks the job in flight, checks it at the output handshake.
    int   acc_edge, first_cyc, n_load, n_step, n_wr;
    logic seen, s_bub, s_byp;
    initial begin
        seen = 1'b0; acc_edge = 0; first_cyc = 0; n_load = 0; n_step = 0; n_wr = 0;
        s_bub = 1'b0; s_byp = 1'b0;
    end

    always @(negedge clk) begin
        if (reset) begin
            seen   = 1'b0;
            n_load = 0; n_step = 0; n_wr = 0;
        end else begin
            if (in_valid && in_ready) begin
                acc_edge = cyc + 1;
                n_load = 0; n_step = 0; n_wr = 0;
                seen = 1'b0;
            end
            if (load) begin
                chk("load_vtx_sel", vtx_sel, n_load);
                n_load++;
            end
            if (step_en) n_step++;
            if (wr_en) n_wr++;
            if (out_valid) begin
                chk("done_in_ready", in_ready, 0);
                if (!seen) begin
                    seen = 1'b1; first_cyc = cyc; s_bub = out_bubble; s_byp = out_bypass;
                end else begin
                    chk("hold_bubble", out_bubble, s_bub);
                    chk("hold_bypass", out_bypass, s_byp);
                end
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_out_valid: got job with empty scoreboard (t=%0t)", $time);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("out_bubble", out_bubble, e.bub);
                        chk("out_bypass", out_bypass, e.byp);
                        chk("latency", first_cyc - acc_edge + 1, e.lat);
                        chk("load_count", n_load, e.nload);
                        chk("step_count", n_step, e.nstep);
                        chk("wr_count", n_wr, e.nwr);
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic bub, input logic en, input int z, input logic rot);
        exp_t e;
        logic acc;
        int   k;
        e.bub = bub;
        e.byp = bub | ~en;
        e.lat = rot ? 73 : 1;
        e.nload = rot ? 4 : 0;
        e.nstep = rot ? 64 : 0;
        e.nwr = rot ? 4 : 0;
        sb_q.push_back(e);
        in_bubble = bub;
        in_enable_cordic = en;
        in_z = ZW'(z);
        in_valid = 1'b1;
        k = 0;
        do begin
            acc = in_ready;
            tick();
            k++;
        end while (!acc && k < 50);
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready never seen, expected 1");
        end
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while (!in_ready && k < bound) begin
            tick();
            k++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: in_ready stayed 0 after %0d cycles, expected 1", bound);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_bubble = 1'b0; in_enable_cordic = 1'b0; in_z = '0;
        out_ready = 1'b1;
        rom_mode = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_load", load, 0);
        chk("rst_step_en", step_en, 0);
        chk("rst_dir", dir, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bubble", out_bubble, 0);
        chk("rst_out_bypass", out_bypass, 0);
        chk("rst_iter_idx", iter_idx, 0);
        chk("rst_vtx_sel", vtx_sel, 0);
        chk("rst_z_cur", z_cur, 0);
        tick();

        // Bypass job
        issue(1'b0, 1'b0, 100, 1'b0);
        chk("byp_out_valid_t1", out_valid, 1);
        wait_idle(20);

        // Bubble job
        issue(1'b1, 1'b1, 0, 1'b0);
        wait_idle(20);

        // Rotated job, z=0, atan=2^(15-i)
        issue(1'b0, 1'b1, 0, 1'b1);
        chk("rot_load0", load, 1);
        chk("rot_vtx0", vtx_sel, 0);
        tick();
        chk("rot_step_en", step_en, 1);
        chk("rot_iter0", iter_idx, 0);
        chk("rot_dir0", dir, 1);
        chk("rot_z0", int'($signed(z_cur)), 0);
        tick();
        chk("rot_z1", int'($signed(z_cur)), -32768);
        chk("rot_dir1", dir, 0);
        chk("rot_iter1", iter_idx, 1);
        tick();
        chk("rot_z2", int'($signed(z_cur)), -16384);
        wait_idle(200);

        // Backpressure
        out_ready = 1'b0;
        issue(1'b0, 1'b0, 7, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_bubble = 1'b1;
            in_enable_cordic = 1'b1;
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_load", load, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle(20);
        issue(1'b1, 1'b0, 5, 1'b0);
        wait_idle(20);

        // Wrap and sign decode
        rom_mode = 1'b1;
        issue(1'b0, 1'b1, -262144, 1'b1);
        tick();
        chk("wrap_dir", dir, 0);
        chk("wrap_z0", int'($signed(z_cur)), -262144);
        tick();
        chk("wrap_z1", int'($signed(z_cur)), -262143);
        wait_idle(200);
        issue(1'b0, 1'b1, 262143, 1'b1);
        tick();
        chk("pos_dir", dir, 1);
        tick();
        chk("pos_z1", int'($signed(z_cur)), 262142);
        wait_idle(200);

        // Reset mid-ITER
        rom_mode = 1'b0;
        issue(1'b0, 1'b1, 1000, 1'b1);
        void'(sb_q.pop_back());
        repeat (5) tick();
        chk("mid_step_en", step_en, 1);
        reset = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_z_cur", z_cur, 0);
        chk("abort_step_en", step_en, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_abort_out_valid", out_valid, 0);
        issue(1'b0, 1'b0, 3, 1'b0);
        wait_idle(20);
        repeat (2) tick();

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
